// File: rtl/bcd_step_counter.sv
// rtl/bcd_step_counter.sv - single-digit BCD up/down counter with prescaler, load and carry/borrow pulse
//
// Ports:
//   clk    - system clock, all state changes on the rising edge
//   rst_n  - synchronous active-low reset
//   run    - 1 = count enabled, 0 = hold count and freeze prescaler
//   up     - count direction, 1 = up, 0 = down (sampled on each step)
//   load   - synchronous parallel load strobe
//   ldata  - load value, 0-9 accepted, 10-15 leave the digit unchanged
//   wdata  - current BCD digit (always 0-9)
//   co     - one-cycle carry (9->0 up) or borrow (0->9 down) pulse
//   tick   - one-cycle pulse on every step
//
// Configuration macro: BCD_STEP_PRESCALE_EN
//   defined     - prescaler of DIV clocks sets the step rate
//   not defined - prescaler removed, the counter steps on every clock with run = 1
module bcd_step_counter #(
    parameter int unsigned DIV = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] ldata,
    output logic [3:0] wdata,
    output logic       co,
    output logic       tick
);

    logic step;

`ifdef BCD_STEP_PRESCALE_EN
    localparam int unsigned PW = $clog2(DIV);
    localparam logic [PW-1:0] PTOP = PW'(DIV - 1);

    logic [PW-1:0] pcnt;

    assign step = run && (pcnt == PTOP);

    // Load and step both restart the period; a paused prescaler keeps its
    // position so the pause does not stretch or shorten the current period.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (load || step) begin
            pcnt <= '0;
        end else if (run) begin
            pcnt <= pcnt + 1'b1;
        end
    end
`else
    logic [31:0] unused_div;

    assign unused_div = DIV;
    assign step       = run;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdata <= 4'd0;
            co    <= 1'b0;
            tick  <= 1'b0;
        end else if (load) begin
            // Out-of-range codes are dropped so wdata never leaves 0-9.
            if (ldata <= 4'd9) begin
                wdata <= ldata;
            end
            co   <= 1'b0;
            tick <= 1'b0;
        end else if (step) begin
            tick <= 1'b1;
            if (up) begin
                if (wdata >= 4'd9) begin
                    wdata <= 4'd0;
                    co    <= 1'b1;
                end else begin
                    wdata <= wdata + 4'd1;
                    co    <= 1'b0;
                end
            end else begin
                if (wdata == 4'd0) begin
                    wdata <= 4'd9;
                    co    <= 1'b1;
                end else begin
                    wdata <= wdata - 4'd1;
                    co    <= 1'b0;
                end
            end
        end else begin
            co   <= 1'b0;
            tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bcd_step_counter.sv
// tb/tb_bcd_step_counter.sv - scoreboard testbench for bcd_step_counter
module tb_bcd_step_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic       up;
    logic       load;
    logic [3:0] ldata;
    logic [3:0] wdata;
    logic       co;
    logic       tick;

    bcd_step_counter #(.DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .up    (up),
        .load  (load),
        .ldata (ldata),
        .wdata (wdata),
        .co    (co),
        .tick  (tick)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] wd;
        logic       co;
        logic       tk;
        string      name;
    } exp_t;

    exp_t q[$];
    bit   done = 1'b0;

    task automatic expect_at(input int c, input logic [3:0] w, input logic c_e,
                             input logic t_e, input string nm);
        exp_t e;
        e.cyc  = c;
        e.wd   = w;
        e.co   = c_e;
        e.tk   = t_e;
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: owns all checking and the counters.
    int   ntest = 0;
    int   nfail = 0;
    exp_t e_cur;
    bit   matched;

    always @(negedge clk) begin
        matched = 1'b0;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e_cur = q.pop_front();
            ntest++;
            nfail++;
            $display("FAIL %s: missed at cycle %0d (now %0d)", e_cur.name, e_cur.cyc, cyc);
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e_cur   = q.pop_front();
            matched = 1'b1;
            ntest++;
            if ({wdata, co, tick} !== {e_cur.wd, e_cur.co, e_cur.tk}) begin
                nfail++;
                $display("FAIL %s: cycle %0d got wdata=%0d co=%0b tick=%0b, want wdata=%0d co=%0b tick=%0b",
                         e_cur.name, cyc, wdata, co, tick, e_cur.wd, e_cur.co, e_cur.tk);
            end
        end
        if (tick === 1'b1 && !matched) begin
            ntest++;
            nfail++;
            $display("FAIL unexpected_tick: cycle %0d wdata=%0d co=%0b, want no tick", cyc, wdata, co);
        end
        if (co === 1'b1) begin
            ntest++;
            if (tick !== 1'b1) begin
                nfail++;
                $display("FAIL co_implies_tick: cycle %0d co=1 tick=%0b, want tick=1", cyc, tick);
            end
        end
        if (done) begin
            ntest++;
            if (q.size() != 0) begin
                nfail++;
                $display("FAIL pending_expectations: %0d left, want 0", q.size());
            end
            $display("[TB] %0d tests run, %0d failed", ntest, nfail);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    int b;

    initial begin
        rst_n = 1'b0;
        run   = 1'b1;
        load  = 1'b1;
        ldata = 4'd5;
        up    = 1'b1;
        expect_at(2, 4'd0, 1'b0, 1'b0, "reset");
        repeat (2) clk_step();
        rst_n = 1'b1;
        load  = 1'b0;
        b     = cyc;
`ifdef BCD_STEP_PRESCALE_EN
        // Up count through the wrap, one step every 4 clocks.
        expect_at(b + 3, 4'd0, 1'b0, 1'b0, "pre_first_step");
        for (int k = 1; k <= 10; k++)
            expect_at(b + 4 * k, 4'(k % 10), (k == 10), 1'b1, "up_wrap");
        repeat (40) clk_step();

        // Down wrap from 0.
        b = cyc; load = 1'b1; ldata = 4'd0; up = 1'b0;
        expect_at(b + 1, 4'd0, 1'b0, 1'b0, "load0");
        expect_at(b + 5, 4'd9, 1'b1, 1'b1, "down_wrap");
        expect_at(b + 9, 4'd8, 1'b0, 1'b1, "down_step");
        clk_step(); load = 1'b0;
        repeat (8) clk_step();

        // Load 7, next step 4 clocks later.
        b = cyc; load = 1'b1; ldata = 4'd7; up = 1'b1;
        expect_at(b + 1, 4'd7, 1'b0, 1'b0, "load7");
        expect_at(b + 5, 4'd8, 1'b0, 1'b1, "load7_step");
        clk_step(); load = 1'b0;
        repeat (4) clk_step();

        // Load 3, then invalid 12 mid-period: digit kept, period restarted.
        b = cyc; load = 1'b1; ldata = 4'd3;
        expect_at(b + 1, 4'd3, 1'b0, 1'b0, "load3");
        clk_step(); load = 1'b0;
        repeat (2) clk_step();
        load = 1'b1; ldata = 4'd12;
        expect_at(b + 4, 4'd3, 1'b0, 1'b0, "load_invalid");
        expect_at(b + 8, 4'd4, 1'b0, 1'b1, "invalid_restart");
        clk_step(); load = 1'b0;
        repeat (4) clk_step();

        // Pause 10 clocks after 2 clocks of a period.
        b = cyc;
        repeat (2) clk_step();
        run = 1'b0;
        expect_at(b + 12, 4'd4, 1'b0, 1'b0, "paused_frozen");
        repeat (10) clk_step();
        run = 1'b1;
        expect_at(b + 14, 4'd5, 1'b0, 1'b1, "resume_step");
        repeat (2) clk_step();

        // Load during pause.
        b = cyc; run = 1'b0; load = 1'b1; ldata = 4'd2;
        expect_at(b + 1, 4'd2, 1'b0, 1'b0, "pause_load");
        clk_step(); load = 1'b0;
        expect_at(b + 4, 4'd2, 1'b0, 1'b0, "pause_hold");
        repeat (3) clk_step();
        run = 1'b1;
        expect_at(cyc + 4, 4'd3, 1'b0, 1'b1, "after_pause_load");
        repeat (4) clk_step();

        // Load on a step-condition edge wins; step lost, period restarts.
        repeat (3) clk_step();
        load = 1'b1; ldata = 4'd6;
        expect_at(cyc + 1, 4'd6, 1'b0, 1'b0, "load_vs_step");
        expect_at(cyc + 5, 4'd7, 1'b0, 1'b1, "load_vs_step_next");
        clk_step(); load = 1'b0;
        repeat (4) clk_step();

        // run drops on a step-condition edge: step held until run returns.
        repeat (3) clk_step();
        run = 1'b0;
        expect_at(cyc + 1, 4'd7, 1'b0, 1'b0, "run_drop_on_step");
        clk_step();
        repeat (2) clk_step();
        run = 1'b1;
        expect_at(cyc + 1, 4'd8, 1'b0, 1'b1, "step_after_run");
        clk_step();

        // Reset mid-period discards the partial period.
        repeat (2) clk_step();
        rst_n = 1'b0;
        expect_at(cyc + 1, 4'd0, 1'b0, 1'b0, "reset_mid");
        clk_step(); rst_n = 1'b1;
        expect_at(cyc + 4, 4'd1, 1'b0, 1'b1, "post_reset_step");
        repeat (4) clk_step();
`else
        // Unprescaled: a step on every clock with run = 1.
        expect_at(b + 1, 4'd1, 1'b0, 1'b1, "first_step");
        clk_step();

        b = cyc; load = 1'b1; ldata = 4'd8; up = 1'b1;
        expect_at(b + 1, 4'd8, 1'b0, 1'b0, "load8");
        expect_at(b + 2, 4'd9, 1'b0, 1'b1, "fast_9");
        expect_at(b + 3, 4'd0, 1'b1, 1'b1, "fast_0");
        expect_at(b + 4, 4'd1, 1'b0, 1'b1, "fast_1");
        clk_step(); load = 1'b0;
        repeat (3) clk_step();

        b = cyc; load = 1'b1; ldata = 4'd0; up = 1'b0;
        expect_at(b + 1, 4'd0, 1'b0, 1'b0, "load0");
        expect_at(b + 2, 4'd9, 1'b1, 1'b1, "fast_down_wrap");
        expect_at(b + 3, 4'd8, 1'b0, 1'b1, "fast_down");
        clk_step(); load = 1'b0;
        repeat (2) clk_step();

        run = 1'b0;
        expect_at(cyc + 3, 4'd8, 1'b0, 1'b0, "hold");
        repeat (3) clk_step();

        load = 1'b1; ldata = 4'd12;
        expect_at(cyc + 1, 4'd8, 1'b0, 1'b0, "load_invalid");
        clk_step(); load = 1'b0;

        run = 1'b1; up = 1'b1;
        expect_at(cyc + 1, 4'd9, 1'b0, 1'b1, "resume_up");
        clk_step();
`endif
        run = 1'b0;
        repeat (3) clk_step();
        done = 1'b1;
    end

endmodule
